gh_tracker: RTL and testbench

GH_TRACKER -- requirements
Module: gh_tracker

---
 rtl/gh_tracker.sv | 161 ++++++++++++++++
 tb/tb_gh_tracker.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gh_tracker.sv
// gh_tracker
//
// Purpose:
//   Keeps the speculative global branch history used by the fetch-side
//   predictor, and checkpoints the pre-branch history of every in-flight
//   conditional branch in a circular FIFO.
//
//   A mispredict rewinds the speculative history from the checkpoint and
//   squashes all younger checkpoints. A commit retires the oldest checkpoint
//   and emits a registered predictor-update strobe.
//
// Ports:
//   CLK, nRST            clock, synchronous active-low reset
//   pred_valid/taken     one predicted conditional branch per cycle
//   pred_ready           checkpoint FIFO has a free slot
//   pred_ckpt_idx        slot the current push will occupy
//   spec_gh              current speculative history
//   resolve_*            backend resolution of a branch (slot, mispredict, direction)
//   commit_valid         oldest branch retired
//   update_valid/gh/taken  registered predictor update for the committed branch

module gh_tracker #(
    parameter int GH_BITS      = 9,
    parameter int CKPT_ENTRIES = 8
) (
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic                            pred_valid,
    input  logic                            pred_taken,
    output logic                            pred_ready,
    output logic [$clog2(CKPT_ENTRIES)-1:0] pred_ckpt_idx,
    output logic [GH_BITS-1:0]              spec_gh,
    input  logic                            resolve_valid,
    input  logic [$clog2(CKPT_ENTRIES)-1:0] resolve_ckpt_idx,
    input  logic                            resolve_mispredict,
    input  logic                            resolve_taken,
    input  logic                            commit_valid,
    output logic                            update_valid,
    output logic [GH_BITS-1:0]              update_gh,
    output logic                            update_taken
);

    localparam int PTR_W = $clog2(CKPT_ENTRIES);
    localparam int CNT_W = PTR_W + 1;

    logic                 r_valid [CKPT_ENTRIES];
    logic [GH_BITS-1:0]   r_gh    [CKPT_ENTRIES];
    logic                 r_taken [CKPT_ENTRIES];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;
    logic [GH_BITS-1:0]   r_specGh;
    logic                 r_updateValid;
    logic [GH_BITS-1:0]   r_updateGh;
    logic                 r_updateTaken;

    logic                 w_resHit;
    logic                 w_mispredict;
    logic                 w_push;
    logic                 w_commit;
    logic                 w_headTaken;
    logic [PTR_W-1:0]     w_idxDist;
    logic                 w_younger [CKPT_ENTRIES];
    logic [CNT_W-1:0]     w_nextCount;
    logic [PTR_W-1:0]     w_nextTail;
    logic [GH_BITS-1:0]   w_nextSpecGh;

    assign pred_ready    = (r_count != CNT_W'(CKPT_ENTRIES));
    assign pred_ckpt_idx = r_tail;
    assign spec_gh       = r_specGh;
    assign update_valid  = r_updateValid;
    assign update_gh     = r_updateGh;
    assign update_taken  = r_updateTaken;

    // Resolutions aimed at a squashed or retired slot are ignored. A
    // mispredict beats a same-cycle push so the pushed branch (which is on the
    // wrong path) never takes a slot.
    assign w_resHit     = resolve_valid && r_valid[resolve_ckpt_idx];
    assign w_mispredict = w_resHit && resolve_mispredict;
    assign w_push       = pred_valid && pred_ready && !w_mispredict;
    assign w_commit     = commit_valid && (r_count != '0);
    assign w_idxDist    = resolve_ckpt_idx - r_head;

    // A head branch resolved in the same cycle it commits reports the freshly
    // resolved direction rather than the stale stored one.
    assign w_headTaken  = (w_resHit && (resolve_ckpt_idx == r_head)) ?
                          resolve_taken : r_taken[r_head];

    // Age of a slot is its distance from head; anything further from head
    // than the mispredicted slot was fetched after it and must be squashed.
    always_comb begin
        for (int k = 0; k < CKPT_ENTRIES; k++) begin
            w_younger[k] = 1'b0;
            w_younger[k] = (PTR_W'(k) - r_head) > w_idxDist;
        end
    end

    // Next tail/count/history. On a mispredict the FIFO is truncated just
    // after the resolved slot; a concurrent commit still removes the head.
    always_comb begin
        w_nextCount  = r_count;
        w_nextTail   = r_tail;
        w_nextSpecGh = r_specGh;
        if (w_mispredict) begin
            w_nextCount  = CNT_W'(w_idxDist) + CNT_W'(1) - CNT_W'(w_commit);
            w_nextTail   = resolve_ckpt_idx + PTR_W'(1);
            w_nextSpecGh = {r_gh[resolve_ckpt_idx][GH_BITS-2:0], resolve_taken};
        end else begin
            w_nextCount = r_count + CNT_W'(w_push) - CNT_W'(w_commit);
            if (w_push) begin
                w_nextTail   = r_tail + PTR_W'(1);
                w_nextSpecGh = {r_specGh[GH_BITS-2:0], pred_taken};
            end
        end
    end

    // Pointer, history, checkpoint storage and update-port registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_specGh      <= '0;
            r_updateValid <= 1'b0;
            r_updateGh    <= '0;
            r_updateTaken <= 1'b0;
            for (int k = 0; k < CKPT_ENTRIES; k++) begin
                r_valid[k] <= 1'b0;
                r_gh[k]    <= '0;
                r_taken[k] <= 1'b0;
            end
        end else begin
            r_tail        <= w_nextTail;
            r_count       <= w_nextCount;
            r_specGh      <= w_nextSpecGh;
            r_updateValid <= w_commit;
            if (w_commit) begin
                r_head        <= r_head + PTR_W'(1);
                r_updateGh    <= r_gh[r_head];
                r_updateTaken <= w_headTaken;
            end
            for (int k = 0; k < CKPT_ENTRIES; k++) begin
                if (w_push && (PTR_W'(k) == r_tail)) begin
                    r_valid[k] <= 1'b1;
                    r_gh[k]    <= r_specGh;
                    r_taken[k] <= pred_taken;
                end
                if (w_resHit && (PTR_W'(k) == resolve_ckpt_idx)) begin
                    r_taken[k] <= resolve_taken;
                end
                if (w_mispredict && w_younger[k]) begin
                    r_valid[k] <= 1'b0;
                end
                if (w_commit && (PTR_W'(k) == r_head)) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gh_tracker.sv
// tb_gh_tracker
//
// Purpose:
//   Self-checking bench for gh_tracker. A queue-based reference model of the
//   in-flight branches predicts every output each cycle; a vector table and
//   a few hand-written sequences check the directed corner cases against
//   constants; a randomized phase exercises everything else.
//
// Ports: none (top-level bench).

module tb_gh_tracker;

    localparam int GHB = 9;
    localparam int NCK = 8;

    logic           CLK;
    logic           nRST;
    logic           pred_valid;
    logic           pred_taken;
    logic           pred_ready;
    logic [2:0]     pred_ckpt_idx;
    logic [GHB-1:0] spec_gh;
    logic           resolve_valid;
    logic [2:0]     resolve_ckpt_idx;
    logic           resolve_mispredict;
    logic           resolve_taken;
    logic           commit_valid;
    logic           update_valid;
    logic [GHB-1:0] update_gh;
    logic           update_taken;

    int total = 0;
    int bad   = 0;

    gh_tracker #(.GH_BITS(GHB), .CKPT_ENTRIES(NCK)) dut (
        .CLK                (CLK),
        .nRST               (nRST),
        .pred_valid         (pred_valid),
        .pred_taken         (pred_taken),
        .pred_ready         (pred_ready),
        .pred_ckpt_idx      (pred_ckpt_idx),
        .spec_gh            (spec_gh),
        .resolve_valid      (resolve_valid),
        .resolve_ckpt_idx   (resolve_ckpt_idx),
        .resolve_mispredict (resolve_mispredict),
        .resolve_taken      (resolve_taken),
        .commit_valid       (commit_valid),
        .update_valid       (update_valid),
        .update_gh          (update_gh),
        .update_taken       (update_taken)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: in-flight branches as a queue, oldest first. Slot
    // number of queue element i is (head + i) mod 8, so the tail and the
    // validity of a slot follow from head and queue length.
    typedef struct {
        logic [GHB-1:0] gh;
        logic           t;
    } entry_t;

    entry_t         mQ[$];
    int             mHead;
    logic [GHB-1:0] mSpec;
    logic           mUpdV;
    logic [GHB-1:0] mUpdGh;
    logic           mUpdT;

    typedef struct {
        logic           pv;
        logic           pt;
        logic           rv;
        logic [2:0]     ridx;
        logic           rmis;
        logic           rt;
        logic           cv;
        logic [GHB-1:0] eSpec;
        logic           eReady;
        logic [2:0]     eIdx;
        logic           eUpdV;
        logic [GHB-1:0] eUpdGh;
        logic           eUpdT;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic pv, input logic pt, input logic rv,
                                 input logic [2:0] ridx, input logic rmis,
                                 input logic rt, input logic cv);
        pred_valid         = pv;
        pred_taken         = pt;
        resolve_valid      = rv;
        resolve_ckpt_idx   = ridx;
        resolve_mispredict = rmis;
        resolve_taken      = rt;
        commit_valid       = cv;
    endtask

    task automatic modelStep();
        int   sz;
        int   pos;
        logic hit;
        logic mis;
        logic push;
        logic com;
        entry_t e;
        if (!nRST) begin
            mQ.delete();
            mHead  = 0;
            mSpec  = '0;
            mUpdV  = 1'b0;
            mUpdGh = '0;
            mUpdT  = 1'b0;
            return;
        end
        sz   = mQ.size();
        pos  = (int'(resolve_ckpt_idx) - mHead) & 7;
        hit  = resolve_valid && (pos < sz);
        mis  = hit && resolve_mispredict;
        push = pred_valid && (sz != NCK) && !mis;
        com  = commit_valid && (sz > 0);
        mUpdV = com;
        if (com) begin
            mUpdGh = mQ[0].gh;
            mUpdT  = (hit && pos == 0) ? resolve_taken : mQ[0].t;
        end
        if (hit) mQ[pos].t = resolve_taken;
        if (mis) begin
            while (mQ.size() > pos + 1) void'(mQ.pop_back());
            mSpec = {mQ[pos].gh[GHB-2:0], resolve_taken};
        end else if (push) begin
            e.gh = mSpec;
            e.t  = pred_taken;
            mQ.push_back(e);
            mSpec = {mSpec[GHB-2:0], pred_taken};
        end
        if (com) begin
            void'(mQ.pop_front());
            mHead = (mHead + 1) & 7;
        end
    endtask

    task automatic compareModel();
        checkOutput("m_spec_gh", 32'(spec_gh), 32'(mSpec));
        checkOutput("m_pred_ready", 32'(pred_ready), 32'(mQ.size() != NCK));
        checkOutput("m_ckpt_idx", 32'(pred_ckpt_idx), 32'((mHead + mQ.size()) & 7));
        checkOutput("m_update_valid", 32'(update_valid), 32'(mUpdV));
        if (mUpdV) begin
            checkOutput("m_update_gh", 32'(update_gh), 32'(mUpdGh));
            checkOutput("m_update_taken", 32'(update_taken), 32'(mUpdT));
        end
    endtask

    // One clock: model consumes the inputs seen at the edge, outputs are
    // compared 1 time unit later.
    task automatic stepCycle();
        @(posedge CLK);
        modelStep();
        #1;
        compareModel();
    endtask

    task automatic doReset();
        nRST = 1'b0;
        applyStimulus(0, 0, 0, 3'd0, 0, 0, 0);
        stepCycle();
        nRST = 1'b1;
    endtask

    initial begin
        logic [GHB-1:0] expHist;
        logic [GHB-1:0] ghQ[$];
        logic           t;

        // Directed vectors, applied right after reset.
        vecs[0]  = '{1,1, 0,3'd0,0,0, 0, 9'h001,1,3'd1, 0,9'h000,0};
        vecs[1]  = '{1,0, 0,3'd0,0,0, 0, 9'h002,1,3'd2, 0,9'h000,0};
        vecs[2]  = '{1,1, 0,3'd0,0,0, 0, 9'h005,1,3'd3, 0,9'h000,0};
        vecs[3]  = '{0,0, 1,3'd1,1,1, 0, 9'h003,1,3'd2, 0,9'h000,0};
        vecs[4]  = '{0,0, 1,3'd2,1,0, 0, 9'h003,1,3'd2, 0,9'h000,0};
        vecs[5]  = '{0,0, 0,3'd0,0,0, 1, 9'h003,1,3'd2, 1,9'h000,1};
        vecs[6]  = '{0,0, 0,3'd0,0,0, 1, 9'h003,1,3'd2, 1,9'h001,1};
        vecs[7]  = '{0,0, 0,3'd0,0,0, 1, 9'h003,1,3'd2, 0,9'h000,0};
        vecs[8]  = '{1,1, 0,3'd0,0,0, 0, 9'h007,1,3'd3, 0,9'h000,0};
        vecs[9]  = '{1,1, 1,3'd2,1,0, 0, 9'h006,1,3'd3, 0,9'h000,0};
        vecs[10] = '{0,0, 1,3'd2,1,1, 1, 9'h007,1,3'd3, 1,9'h003,1};
        vecs[11] = '{0,0, 0,3'd0,0,0, 0, 9'h007,1,3'd3, 0,9'h000,0};

        nRST = 1'b0;
        applyStimulus(0, 0, 0, 3'd0, 0, 0, 0);
        repeat (2) stepCycle();
        checkOutput("reset_spec_gh", 32'(spec_gh), 32'h0);
        checkOutput("reset_ready", 32'(pred_ready), 32'h1);
        checkOutput("reset_idx", 32'(pred_ckpt_idx), 32'h0);
        checkOutput("reset_update_valid", 32'(update_valid), 32'h0);
        nRST = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].pv, vecs[i].pt, vecs[i].rv, vecs[i].ridx,
                          vecs[i].rmis, vecs[i].rt, vecs[i].cv);
            stepCycle();
            checkOutput($sformatf("vec%0d_spec_gh", i), 32'(spec_gh), 32'(vecs[i].eSpec));
            checkOutput($sformatf("vec%0d_ready", i), 32'(pred_ready), 32'(vecs[i].eReady));
            checkOutput($sformatf("vec%0d_idx", i), 32'(pred_ckpt_idx), 32'(vecs[i].eIdx));
            checkOutput($sformatf("vec%0d_upd_valid", i), 32'(update_valid), 32'(vecs[i].eUpdV));
            if (vecs[i].eUpdV) begin
                checkOutput($sformatf("vec%0d_upd_gh", i), 32'(update_gh), 32'(vecs[i].eUpdGh));
                checkOutput($sformatf("vec%0d_upd_taken", i), 32'(update_taken), 32'(vecs[i].eUpdT));
            end
        end

        // Fill to full, drop a push while full, free one slot by commit.
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1, 0, 3'd0, 0, 0, 0);
            stepCycle();
        end
        checkOutput("full_ready", 32'(pred_ready), 32'h0);
        checkOutput("full_spec_gh", 32'(spec_gh), 32'h0FF);
        applyStimulus(1, 0, 0, 3'd0, 0, 0, 0);
        stepCycle();
        checkOutput("drop_spec_gh", 32'(spec_gh), 32'h0FF);
        checkOutput("drop_idx", 32'(pred_ckpt_idx), 32'h0);
        applyStimulus(0, 0, 0, 3'd0, 0, 0, 1);
        stepCycle();
        checkOutput("commit_ready", 32'(pred_ready), 32'h1);
        checkOutput("commit_upd_gh", 32'(update_gh), 32'h000);
        applyStimulus(1, 1, 0, 3'd0, 0, 0, 0);
        stepCycle();
        checkOutput("refill_spec_gh", 32'(spec_gh), 32'h1FF);
        // Push plus commit while full: the push is dropped.
        applyStimulus(1, 0, 0, 3'd0, 0, 0, 1);
        stepCycle();
        checkOutput("fullpc_spec_gh", 32'(spec_gh), 32'h1FF);
        checkOutput("fullpc_ready", 32'(pred_ready), 32'h1);
        checkOutput("fullpc_upd_gh", 32'(update_gh), 32'h001);
        applyStimulus(1, 1, 0, 3'd0, 0, 0, 0);
        stepCycle();
        // Reset with a full FIFO and every request active.
        nRST = 1'b0;
        applyStimulus(1, 1, 1, 3'd3, 1, 1, 1);
        stepCycle();
        checkOutput("rstfull_spec_gh", 32'(spec_gh), 32'h0);
        checkOutput("rstfull_ready", 32'(pred_ready), 32'h1);
        checkOutput("rstfull_idx", 32'(pred_ckpt_idx), 32'h0);
        checkOutput("rstfull_upd_valid", 32'(update_valid), 32'h0);
        nRST = 1'b1;

        // Twenty push/commit pairs to wrap the pointers.
        doReset();
        expHist = '0;
        t = 1'($urandom_range(0, 1));
        ghQ.push_back(expHist);
        expHist = {expHist[GHB-2:0], t};
        applyStimulus(1, t, 0, 3'd0, 0, 0, 0);
        stepCycle();
        for (int i = 0; i < 20; i++) begin
            t = 1'($urandom_range(0, 1));
            ghQ.push_back(expHist);
            expHist = {expHist[GHB-2:0], t};
            applyStimulus(1, t, 0, 3'd0, 0, 0, 1);
            stepCycle();
            checkOutput($sformatf("wrap%0d_upd_gh", i), 32'(update_gh), 32'(ghQ.pop_front()));
            checkOutput($sformatf("wrap%0d_idx", i), 32'(pred_ckpt_idx), 32'((i + 2) % 8));
            checkOutput($sformatf("wrap%0d_spec_gh", i), 32'(spec_gh), 32'(expHist));
        end

        // Randomized traffic against the model.
        doReset();
        for (int i = 0; i < 2000; i++) begin
            nRST = ($urandom_range(0, 299) != 0);
            applyStimulus(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 9) < 4));
            stepCycle();
        end
        nRST = 1'b1;
        applyStimulus(0, 0, 0, 3'd0, 0, 0, 0);
        stepCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
